// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared constants, state encoding and header byte helper for the UDP receive path
package udp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_ETH_HDR,
    ST_IP_HDR,
    ST_UDP_HDR,
    ST_PAYLOAD,
    ST_TAIL,
    ST_DROP
  } rx_state_e;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [31:0] CRC_RESIDUE    = 32'hC704DD7B;
  localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;
  localparam logic [4:0]  ETH_HDR_LEN    = 5'd14;
  localparam logic [4:0]  IP_HDR_LEN     = 5'd20;
  localparam logic [4:0]  UDP_HDR_LEN    = 5'd8;
  localparam logic [3:0]  NIB_PRE        = 4'h5;
  localparam logic [3:0]  NIB_SFD        = 4'hD;

  // Byte idx (0 = most significant) of a left-aligned big-endian field.
  function automatic logic [7:0] hdr_byte(input logic [47:0] field, input logic [2:0] idx);
    logic [47:0] sh;
    sh = field << {idx, 3'b000};
    return sh[47:40];
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - combinational byte-wise CRC-32 next state, data bits fed LSB first
module crc32_d8 (
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  localparam logic [31:0] POLY = 32'h04C11DB7;

  always_comb begin
    logic [31:0] c;
    logic        fb;
    c = crc_i;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data_i[i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    crc_o = c;
  end

endmodule

// File: rtl/udp_rx.sv
// rtl/udp_rx.sv - MII receive: preamble strip, Ethernet/IPv4/UDP filter, payload stream, CRC verdict
module udp_rx
  import udp_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC  = 48'h00_0A_35_01_FE_C0,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0002,
  parameter logic [15:0] LOCAL_PORT = 16'd8080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ETH_RX_DV,
  input  logic        ETH_RX_ER,
  input  logic [3:0]  ETH_RX_DATA,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_last,
  output logic [15:0] rx_len,
  output logic [31:0] rx_src_ip,
  output logic [15:0] rx_src_port,
  output logic        frame_done,
  output logic        frame_ok
);

  rx_state_e   state_q;
  logic        phase_q;
  logic [3:0]  lo_q;
  logic [7:0]  byte_q;
  logic        byte_stb_q;
  logic [4:0]  cnt_q;
  logic        mac_uc_q;
  logic        mac_bc_q;
  logic [31:0] src_ip_sh_q;
  logic [15:0] src_port_sh_q;
  logic [15:0] udp_len_q;
  logic [15:0] pay_cnt_q;
  logic        hdr_done_q;
  logic        er_seen_q;
  logic [31:0] crc_q;

  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        rx_last_q;
  logic [15:0] rx_len_q;
  logic [31:0] rx_src_ip_q;
  logic [15:0] rx_src_port_q;
  logic        frame_done_q;
  logic        frame_ok_q;

  logic [31:0] crc_nx;
  logic [31:0] crc_fin;
  logic        in_frame;
  logic [15:0] pay_inc;
  logic        last_now;
  logic        all_delivered;
  logic        uc_hit;
  logic        bc_hit;
  logic [7:0]  ip_exp;
  logic [7:0]  port_exp;
  logic [15:0] len_full;

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (byte_q),
    .crc_o  (crc_nx)
  );

  // A byte that completed on the previous edge is still folded in when DV falls.
  always_comb begin
    in_frame      = (state_q == ST_ETH_HDR) || (state_q == ST_IP_HDR) || (state_q == ST_UDP_HDR) ||
                    (state_q == ST_PAYLOAD) || (state_q == ST_TAIL);
    crc_fin       = byte_stb_q ? crc_nx : crc_q;
    pay_inc       = pay_cnt_q + 16'd1;
    last_now      = (state_q == ST_PAYLOAD) && byte_stb_q && (pay_inc == rx_len_q);
    all_delivered = (state_q == ST_TAIL) || last_now;
    uc_hit        = mac_uc_q && (byte_q == hdr_byte(LOCAL_MAC, cnt_q[2:0]));
    bc_hit        = mac_bc_q && (byte_q == 8'hFF);
    ip_exp        = hdr_byte({LOCAL_IP, 16'h0}, cnt_q[2:0]);
    port_exp      = hdr_byte({LOCAL_PORT, 32'h0}, cnt_q[2:0] - 3'd2);
    len_full      = {udp_len_q[7:0], byte_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      phase_q       <= 1'b0;
      lo_q          <= 4'h0;
      byte_q        <= 8'h0;
      byte_stb_q    <= 1'b0;
      cnt_q         <= 5'd0;
      mac_uc_q      <= 1'b0;
      mac_bc_q      <= 1'b0;
      src_ip_sh_q   <= 32'h0;
      src_port_sh_q <= 16'h0;
      udp_len_q     <= 16'h0;
      pay_cnt_q     <= 16'h0;
      hdr_done_q    <= 1'b0;
      er_seen_q     <= 1'b0;
      crc_q         <= CRC_INIT;
      rx_data_q     <= 8'h0;
      rx_valid_q    <= 1'b0;
      rx_last_q     <= 1'b0;
      rx_len_q      <= 16'h0;
      rx_src_ip_q   <= 32'h0;
      rx_src_port_q <= 16'h0;
      frame_done_q  <= 1'b0;
      frame_ok_q    <= 1'b0;
    end else begin
      rx_valid_q   <= 1'b0;
      rx_last_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      byte_stb_q   <= 1'b0;

      if (in_frame && ETH_RX_DV) begin
        if (!phase_q) begin
          lo_q    <= ETH_RX_DATA;
          phase_q <= 1'b1;
        end else begin
          byte_q     <= {ETH_RX_DATA, lo_q};
          byte_stb_q <= 1'b1;
          phase_q    <= 1'b0;
        end
        if (ETH_RX_ER) er_seen_q <= 1'b1;
      end
      if (in_frame && byte_stb_q) crc_q <= crc_nx;

      case (state_q)
        ST_IDLE: begin
          if (ETH_RX_DV && ETH_RX_DATA == NIB_PRE) begin
            state_q    <= ST_PREAMBLE;
            er_seen_q  <= ETH_RX_ER;
            hdr_done_q <= 1'b0;
          end
        end
        ST_PREAMBLE: begin
          if (!ETH_RX_DV) begin
            state_q <= ST_IDLE;
          end else begin
            if (ETH_RX_ER) er_seen_q <= 1'b1;
            if (ETH_RX_DATA == NIB_SFD) begin
              state_q  <= ST_ETH_HDR;
              phase_q  <= 1'b0;
              cnt_q    <= 5'd0;
              crc_q    <= CRC_INIT;
              mac_uc_q <= 1'b1;
              mac_bc_q <= 1'b1;
            end else if (ETH_RX_DATA != NIB_PRE) begin
              state_q <= ST_DROP;
            end
          end
        end
        ST_ETH_HDR: begin
          if (byte_stb_q) begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q < 5'd6) begin
              mac_uc_q <= uc_hit;
              mac_bc_q <= bc_hit;
              if (!uc_hit && !bc_hit) state_q <= ST_DROP;
            end else if (cnt_q == ETH_HDR_LEN - 5'd2) begin
              if (byte_q != ETHERTYPE_IPV4[15:8]) state_q <= ST_DROP;
            end else if (cnt_q == ETH_HDR_LEN - 5'd1) begin
              if (byte_q != ETHERTYPE_IPV4[7:0]) begin
                state_q <= ST_DROP;
              end else begin
                state_q <= ST_IP_HDR;
                cnt_q   <= 5'd0;
              end
            end
          end
        end
        ST_IP_HDR: begin
          if (byte_stb_q) begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd0 && byte_q != IP_VER_IHL) state_q <= ST_DROP;
            if (cnt_q == 5'd9 && byte_q != IP_PROTO_UDP) state_q <= ST_DROP;
            if (cnt_q >= 5'd12 && cnt_q <= 5'd15) src_ip_sh_q <= {src_ip_sh_q[23:0], byte_q};
            if (cnt_q >= 5'd16) begin
              if (byte_q != ip_exp) begin
                state_q <= ST_DROP;
              end else if (cnt_q == IP_HDR_LEN - 5'd1) begin
                state_q     <= ST_UDP_HDR;
                cnt_q       <= 5'd0;
                rx_src_ip_q <= src_ip_sh_q;
              end
            end
          end
        end
        ST_UDP_HDR: begin
          if (byte_stb_q) begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q <= 5'd1) src_port_sh_q <= {src_port_sh_q[7:0], byte_q};
            if ((cnt_q == 5'd2 || cnt_q == 5'd3) && byte_q != port_exp) state_q <= ST_DROP;
            if (cnt_q == 5'd4 || cnt_q == 5'd5) udp_len_q <= len_full;
            if (cnt_q == 5'd5 && len_full < 16'd8) state_q <= ST_DROP;
            if (cnt_q == UDP_HDR_LEN - 5'd1) begin
              rx_len_q      <= udp_len_q - 16'd8;
              rx_src_port_q <= src_port_sh_q;
              hdr_done_q    <= 1'b1;
              pay_cnt_q     <= 16'h0;
              state_q       <= (udp_len_q == 16'd8) ? ST_TAIL : ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (byte_stb_q) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= byte_q;
            pay_cnt_q  <= pay_inc;
            if (pay_inc == rx_len_q) begin
              rx_last_q <= 1'b1;
              state_q   <= ST_TAIL;
            end
          end
        end
        ST_TAIL: begin
        end
        ST_DROP: begin
          if (!ETH_RX_DV) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      // End of frame overrides whatever the byte handling above decided.
      if (in_frame && !ETH_RX_DV) begin
        state_q <= ST_IDLE;
        if (hdr_done_q) begin
          frame_done_q <= 1'b1;
          frame_ok_q   <= (crc_fin == CRC_RESIDUE) && !er_seen_q && !phase_q && all_delivered;
        end
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_last     = rx_last_q;
  assign rx_len      = rx_len_q;
  assign rx_src_ip   = rx_src_ip_q;
  assign rx_src_port = rx_src_port_q;
  assign frame_done  = frame_done_q;
  assign frame_ok    = frame_ok_q;

endmodule

// File: tb/tb_udp_rx.sv
// tb/tb_udp_rx.sv - scoreboard bench for udp_rx
module tb_udp_rx;

  localparam logic [47:0] LMAC  = 48'h000A3501FEC0;
  localparam logic [31:0] LIP   = 32'hC0A80002;
  localparam logic [15:0] LPORT = 16'd8080;
  localparam logic [47:0] SMAC  = 48'h020000000001;
  localparam logic [31:0] SIP   = 32'hC0A8000A;
  localparam logic [15:0] SPORT = 16'h04D2;
  localparam int          PAY0  = 42;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dv  = 1'b0;
  logic        er  = 1'b0;
  logic [3:0]  nib = 4'h0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_last;
  logic [15:0] rx_len;
  logic [31:0] rx_src_ip;
  logic [15:0] rx_src_port;
  logic        frame_done;
  logic        frame_ok;

  udp_rx #(.LOCAL_MAC(LMAC), .LOCAL_IP(LIP), .LOCAL_PORT(LPORT)) dut (
    .clk         (clk),
    .rst         (rst),
    .ETH_RX_DV   (dv),
    .ETH_RX_ER   (er),
    .ETH_RX_DATA (nib),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_last     (rx_last),
    .rx_len      (rx_len),
    .rx_src_ip   (rx_src_ip),
    .rx_src_port (rx_src_port),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic [15:0] len;
  } exp_t;

  exp_t       exp_q[$];
  logic       exp_done_q[$];
  logic [7:0] frm[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  // Output monitor: every strobe and frame_done is matched against the scoreboard.
  initial begin
    exp_t mon_e;
    logic mon_ok;
    int   mon_cyc;
    int   last_cyc;
    mon_cyc  = 0;
    last_cyc = -1;
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (!rst) begin
        last_cyc = -1;
      end else begin
        if (rx_valid) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe: got rx_data=%h rx_last=%b, none expected", rx_data, rx_last);
          end else begin
            mon_e = exp_q.pop_front();
            if (rx_data !== mon_e.data || rx_last !== mon_e.last || rx_len !== mon_e.len) begin
              n_fail++;
              $display("FAIL payload_byte: got data=%h last=%b len=%0d, expected data=%h last=%b len=%0d",
                       rx_data, rx_last, rx_len, mon_e.data, mon_e.last, mon_e.len);
            end
          end
          if (last_cyc >= 0) begin
            n_checks++;
            if (mon_cyc - last_cyc !== 2) begin
              n_fail++;
              $display("FAIL strobe_spacing: got %0d cycles, expected 2", mon_cyc - last_cyc);
            end
          end
          last_cyc = rx_last ? -1 : mon_cyc;
        end
        if (frame_done) begin
          n_checks++;
          last_cyc = -1;
          if (exp_done_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_frame_done: got frame_ok=%b, no frame_done expected", frame_ok);
          end else begin
            mon_ok = exp_done_q.pop_front();
            if (frame_ok !== mon_ok) begin
              n_fail++;
              $display("FAIL frame_ok: got %b, expected %b", frame_ok, mon_ok);
            end
          end
        end
      end
    end
  end

  function automatic logic [31:0] crc_ref();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < frm.size(); i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build_frame(input logic [47:0] dmac, input logic [31:0] dip, input logic [7:0] proto,
                             input logic [15:0] dport, input logic [15:0] ulen, input int npay,
                             input int flip);
    logic [31:0] c;
    logic [15:0] iplen;
    logic [7:0]  pb;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(dmac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(SMAC[47-8*i -: 8]);
    frm.push_back(8'h08); frm.push_back(8'h00);
    iplen = 16'd20 + ulen;
    frm.push_back(8'h45); frm.push_back(8'h00); frm.push_back(iplen[15:8]); frm.push_back(iplen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h40); frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(proto); frm.push_back(8'h00); frm.push_back(8'h00);
    for (int i = 0; i < 4; i++) frm.push_back(SIP[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) frm.push_back(dip[31-8*i -: 8]);
    frm.push_back(SPORT[15:8]); frm.push_back(SPORT[7:0]);
    frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
    frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00);
    for (int i = 0; i < npay; i++) begin
      pb = i[7:0];
      frm.push_back(pb);
    end
    while (frm.size() < 60) frm.push_back(8'h00);
    c = ~crc_ref();
    frm.push_back(c[7:0]); frm.push_back(c[15:8]); frm.push_back(c[23:16]); frm.push_back(c[31:24]);
    if (flip >= 0) frm[flip] = frm[flip] ^ 8'h01;
  endtask

  task automatic push_payload(input int n, input int len);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = frm[PAY0+i];
      e.last = (i == len - 1);
      e.len  = len[15:0];
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_nib(input logic [3:0] v);
    @(negedge clk);
    dv  = 1'b1;
    er  = 1'b0;
    nib = v;
  endtask

  task automatic drive_frame(input int cut_bytes, input int er_nib, input int rst_nib, input int gap);
    int n;
    n = (cut_bytes >= 0) ? cut_bytes : frm.size();
    for (int i = 0; i < 15; i++) drive_nib(4'h5);
    drive_nib(4'hD);
    for (int k = 0; k < 2 * n; k++) begin
      drive_nib(k[0] ? frm[k/2][7:4] : frm[k/2][3:0]);
      er = (k == er_nib);
      if (k == rst_nib) begin
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({rx_valid, rx_last, frame_done, frame_ok, rx_data, rx_len, rx_src_ip, rx_src_port} !== '0) begin
          n_fail++;
          $display("FAIL async_reset_clear: got valid=%b len=%0d ip=%h port=%h, expected all zero",
                   rx_valid, rx_len, rx_src_ip, rx_src_port);
        end
        @(negedge clk);
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    dv  = 1'b0;
    er  = 1'b0;
    nib = 4'h0;
    for (int i = 1; i < gap; i++) @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    repeat (8) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || exp_done_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: got %0d strobes and %0d frame_done outstanding, expected 0 and 0",
               name, exp_q.size(), exp_done_q.size());
    end
  endtask

  task automatic check_fields(input string name, input logic [15:0] len);
    n_checks++;
    if (rx_len !== len || rx_src_ip !== SIP || rx_src_port !== SPORT) begin
      n_fail++;
      $display("FAIL %s_fields: got len=%0d ip=%h port=%h, expected len=%0d ip=%h port=%h",
               name, rx_len, rx_src_ip, rx_src_port, len, SIP, SPORT);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rx_valid, rx_last, frame_done, frame_ok} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got valid/last/done/ok=%b%b%b%b, expected 0000", rx_valid, rx_last, frame_done, frame_ok);
    end
    n_checks++;
    if (rx_data !== 8'h0 || rx_len !== 16'h0 || rx_src_ip !== 32'h0 || rx_src_port !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_fields: got data=%h len=%h ip=%h port=%h, expected zeros", rx_data, rx_len, rx_src_ip, rx_src_port);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_valid_frame();
    build_frame(LMAC, LIP, 8'd17, LPORT, 16'd26, 18, -1);
    push_payload(18, 18);
    exp_done_q.push_back(1'b1);
    drive_frame(-1, -1, -1, 4);
    check_drained("valid");
    check_fields("valid", 16'd18);
  endtask

  task automatic test_bad_crc();
    build_frame(LMAC, LIP, 8'd17, LPORT, 16'd26, 18, PAY0 + 4);
    push_payload(18, 18);
    exp_done_q.push_back(1'b0);
    drive_frame(-1, -1, -1, 4);
    check_drained("bad_crc");
  endtask

  task automatic test_drops();
    build_frame(LMAC, LIP, 8'd17, 16'd8081, 16'd26, 18, -1);
    drive_frame(-1, -1, -1, 4);
    build_frame(48'h000A3501FEC1, LIP, 8'd17, LPORT, 16'd26, 18, -1);
    drive_frame(-1, -1, -1, 4);
    build_frame(LMAC, LIP, 8'd6, LPORT, 16'd26, 18, -1);
    drive_frame(-1, -1, -1, 4);
    check_drained("drops");
  endtask

  task automatic test_broadcast_empty();
    build_frame(48'hFFFFFFFFFFFF, LIP, 8'd17, LPORT, 16'd8, 0, -1);
    exp_done_q.push_back(1'b1);
    drive_frame(-1, -1, -1, 4);
    check_drained("bcast");
    check_fields("bcast", 16'd0);
  endtask

  task automatic test_back_to_back();
    build_frame(LMAC, LIP, 8'd17, LPORT, 16'd26, 18, -1);
    push_payload(5, 18);
    exp_done_q.push_back(1'b0);
    drive_frame(PAY0 + 5, -1, -1, 1);
    build_frame(LMAC, LIP, 8'd17, LPORT, 16'd26, 18, -1);
    push_payload(18, 18);
    exp_done_q.push_back(1'b1);
    drive_frame(-1, -1, -1, 4);
    check_drained("back_to_back");
    check_fields("back_to_back", 16'd18);
  endtask

  task automatic test_rx_er();
    build_frame(LMAC, LIP, 8'd17, LPORT, 16'd26, 18, -1);
    push_payload(18, 18);
    exp_done_q.push_back(1'b0);
    drive_frame(-1, 2 * (PAY0 + 3), -1, 4);
    check_drained("rx_er");
  endtask

  task automatic test_async_reset();
    build_frame(LMAC, LIP, 8'd17, LPORT, 16'd26, 18, -1);
    push_payload(8, 18);
    drive_frame(-1, -1, 2 * (PAY0 + 8) + 1, 4);
    check_drained("reset_frame");
    build_frame(LMAC, LIP, 8'd17, LPORT, 16'd26, 18, -1);
    push_payload(18, 18);
    exp_done_q.push_back(1'b1);
    drive_frame(-1, -1, -1, 4);
    check_drained("after_reset");
    check_fields("after_reset", 16'd18);
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_crc();
    test_drops();
    test_broadcast_empty();
    test_back_to_back();
    test_rx_er();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
